image_reader_14x14: RTL
=======================

Name: image_reader_14x14

Overview:
- Upstream input stage of the MNIST accelerator.
- Deserialises a 14x14 binary image arriving 7 pixels per beat over 28 beats into a 196-bit image vector.
- Presents the vector to the inference/classification stage with a ready/ack handshake.
- Flags a protocol error when beats arrive while a completed image is still unconsumed.

Parameters:
- ROW_BITS, 7, pixels per input beat (width of data_in).
- BEATS, 28, beats per image; image width IMG_W = ROW_BITS*BEATS = 196.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- frame_start  input  1  pulse: abort any partial load and restart at beat 0.
- data_in  input  ROW_BITS  pixel beat; bit i = pixel i of the beat.
- data_valid  input  1  data_in is valid this cycle.
- image_ack  input  1  downstream has consumed image_data.
- image_data  output  IMG_W  assembled image; beat k occupies bits [ROW_BITS*k+ROW_BITS-1 : ROW_BITS*k].
- image_ready  output  1  image_data complete and stable.
- beat_count  output  $clog2(BEATS)+1  beats captured in current frame (0..BEATS).
- overrun  output  1  sticky: data_valid seen while image_ready=1.

Behaviour:
- Reset: sampled on the rising edge of clk with rst=1.
  - Reset values: state=LOAD, image_data=0, image_ready=0, beat_count=0, overrun=0.
  - rst mid-load discards the partial frame.
- States:
  - LOAD: accepting beats.
  - READY: image held for downstream.
  - ERR: optional feature only.
- LOAD:
  - Each cycle with data_valid=1: write data_in into slot beat_count, then beat_count+1.
  - No other image_data bits change.
  - On the beat that makes beat_count=BEATS: next cycle image_ready=1, state=READY.
  - Latency: image_ready asserts exactly 1 cycle after the 28th accepted beat.
- frame_start in LOAD:
  - Resets beat_count to 0; image_data is not cleared.
  - If data_valid=1 in the same cycle, that beat is written to slot 0 and beat_count=1.
- READY:
  - image_data and beat_count frozen (beat_count=BEATS).
  - data_valid=1 sets overrun=1; the beat is dropped.
  - frame_start is ignored.
- image_ack in READY: next cycle image_ready=0, beat_count=0, state=LOAD.
  - A data_valid in the ack cycle is dropped and sets overrun.
  - The first beat accepted is on the cycle after ack.
- image_ack outside READY: no effect.
- overrun clears only on rst or frame_start (frame_start clears it in any state).
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: IMAGE_READER_CHECKSUM_EN.
- Defined:
  - One extra beat follows beat BEATS-1, carrying the XOR of all 28 data beats.
  - After beat 28, state=CHECK.
  - Next valid beat is compared with the running XOR.
    - Match: image_ready=1 next cycle.
    - Mismatch: state=ERR; adds output ckerr=1 (registered, reset 0); image_ready stays 0.
  - ERR exits only on frame_start (to LOAD, beat_count=0, ckerr=0) or rst.
  - beat_count stays BEATS during CHECK.
- Undefined:
  - No checksum beat, no CHECK/ERR states.
  - ckerr port absent.

Test Plan:
- Reset then 28 beats data_in=7'h01 with data_valid=1 back-to-back -> image_ready=1 one cycle after beat 28; image_data bit 7k=1 for k=0..27, all other bits 0; beat_count=28.
- Beats with gaps (data_valid toggling 1/0) carrying k[6:0] for beat k -> slot k=k, image_ready only after 28th valid beat; ack -> image_ready=0 next cycle, beat_count=0.
- 10 beats of 7'h7F, frame_start with data_valid=1 data=7'h2A, then 27 beats 7'h00 -> image_data[6:0]=7'h2A, bits [195:7]=0.
- While READY, data_valid=1 data=7'h55 -> overrun=1, image_data unchanged; ack then frame_start -> overrun=0.
- rst asserted after 15 beats -> all outputs 0 next cycle; 28 new beats yield a correct image.
- IMAGE_READER_CHECKSUM_EN:
  - beats 0..27 = k, checksum beat = XOR of 0..27 = 7'h00 -> image_ready=1.
  - Same frame with checksum 7'h01 -> ckerr=1, image_ready=0; frame_start -> ckerr=0.

Source files
------------

// File: rtl/image_reader_14x14.sv
// Purpose : deserialises a 14x14 binary image (7 pixels/beat, 28 beats) into a 196-bit vector.
// Latency : image_ready rises 1 cycle after the last accepted beat; all outputs registered.
// Backpr. : no input backpressure; beats arriving while an image is held are dropped and flag overrun.
// Option  : define IMAGE_READER_CHECKSUM_EN to require a trailing XOR checksum beat (adds ckerr).
module image_reader_14x14 #(
  parameter int ROW_BITS = 7,
  parameter int BEATS    = 28,
  localparam int IMG_W   = ROW_BITS * BEATS,
  localparam int CW      = $clog2(BEATS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic [ROW_BITS-1:0] data_in,
  input  logic                data_valid,
  input  logic                image_ack,
  output logic [IMG_W-1:0]    image_data,
  output logic                image_ready,
  output logic [CW-1:0]       beat_count,
  output logic                overrun
`ifdef IMAGE_READER_CHECKSUM_EN
  ,
  output logic                ckerr
`endif
);

`ifdef IMAGE_READER_CHECKSUM_EN
  typedef enum logic [1:0] {S_LOAD, S_READY, S_CHECK, S_ERR} state_t;
  logic [ROW_BITS-1:0] xor_q, xor_d;
  logic                ckerr_d;
`else
  typedef enum logic [1:0] {S_LOAD, S_READY} state_t;
`endif

  state_t            state_q, state_d;
  logic [IMG_W-1:0]  image_d;
  logic              ready_d;
  logic [CW-1:0]     cnt_d;
  logic [CW-1:0]     slot;
  logic              ovr_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d = state_q;
    image_d = image_data;
    ready_d = image_ready;
    cnt_d   = beat_count;
    ovr_d   = overrun;
    slot    = beat_count;
`ifdef IMAGE_READER_CHECKSUM_EN
    xor_d   = xor_q;
    ckerr_d = ckerr;
`endif
    // frame_start clears overrun anywhere; a dropped beat in READY below still re-sets it
    if (frame_start) ovr_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (frame_start) begin
          slot  = '0;
          cnt_d = '0;
`ifdef IMAGE_READER_CHECKSUM_EN
          xor_d = '0;
`endif
        end
        if (data_valid) begin
          for (int k = 0; k < BEATS; k++) begin
            if (slot == CW'(k)) image_d[k*ROW_BITS +: ROW_BITS] = data_in;
          end
          cnt_d = slot + CW'(1);
`ifdef IMAGE_READER_CHECKSUM_EN
          xor_d = xor_d ^ data_in;
          if (cnt_d == CW'(BEATS)) state_d = S_CHECK;
`else
          if (cnt_d == CW'(BEATS)) begin
            state_d = S_READY;
            ready_d = 1'b1;
          end
`endif
        end
      end
      S_READY: begin
        if (data_valid) ovr_d = 1'b1;
        if (image_ack) begin
          state_d = S_LOAD;
          ready_d = 1'b0;
          cnt_d   = '0;
`ifdef IMAGE_READER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
`ifdef IMAGE_READER_CHECKSUM_EN
      // Waiting for the checksum beat; frame_start abandons the frame (that cycle's beat is dropped)
      S_CHECK: begin
        if (frame_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          xor_d   = '0;
        end else if (data_valid) begin
          if (data_in == xor_q) begin
            state_d = S_READY;
            ready_d = 1'b1;
          end else begin
            state_d = S_ERR;
            ckerr_d = 1'b1;
          end
        end
      end
      S_ERR: begin
        if (frame_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          ckerr_d = 1'b0;
          xor_d   = '0;
        end
      end
`endif
      default: state_d = S_LOAD;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      image_data  <= '0;
      image_ready <= 1'b0;
      beat_count  <= '0;
      overrun     <= 1'b0;
`ifdef IMAGE_READER_CHECKSUM_EN
      xor_q       <= '0;
      ckerr       <= 1'b0;
`endif
    end else begin
      image_data  <= image_d;
      image_ready <= ready_d;
      beat_count  <= cnt_d;
      overrun     <= ovr_d;
`ifdef IMAGE_READER_CHECKSUM_EN
      xor_q       <= xor_d;
      ckerr       <= ckerr_d;
`endif
    end
  end

endmodule
